// File: rtl/ocimem_arb_pkg.sv
// ocimem_arb_pkg: shared state encoding, jdo field offsets and data width for the OCI RAM arbiter
package ocimem_arb_pkg;
  localparam int OCIMEM_DATA_W = 32;
  localparam int JDO_ADDR_LSB = 17;
  localparam int JDO_WDATA_LSB = 3;
  typedef enum logic [1:0] {IDLE, CPU_RD, JTAG_RD} ocimem_state_e;
endpackage

// File: rtl/ocimem_jtag_cmd_latch.sv
// ocimem_jtag_cmd_latch: JTAG pointer, pending read/write flags, write-data capture and overrun flag (OCIMEM_JTAG_AUTOINC_EN enables pointer post-increment)
module ocimem_jtag_cmd_latch
  import ocimem_arb_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [37:0]              jdo,
  input  logic                     take_action_ocimem_a,
  input  logic                     take_action_ocimem_b,
  input  logic                     take_no_action_ocimem_a,
  input  logic                     wr_done,
  input  logic                     rd_done,
  output logic [ADDR_W-1:0]        jptr,
  output logic                     wr_pend,
  output logic                     rd_pend,
  output logic [OCIMEM_DATA_W-1:0] wdata,
  output logic                     monitor_error
);
`ifdef OCIMEM_JTAG_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif
  logic [ADDR_W-1:0] jptr_q, jptr_d;
  logic wr_pend_q, wr_pend_d, rd_pend_q, rd_pend_d, err_q, err_d;
  logic [OCIMEM_DATA_W-1:0] wdata_q, wdata_d;
  logic unused_jdo;
  assign unused_jdo = ^{jdo[37:35], jdo[2:0]};
  // A new pulse always re-arms its flag; hitting an already-set flag is an overrun, cleared by an address load
  always_comb begin
    jptr_d = take_action_ocimem_a ? jdo[JDO_ADDR_LSB +: ADDR_W] :
             (AUTOINC && (wr_done || rd_done)) ? jptr_q + 1'b1 : jptr_q;
    wr_pend_d = take_action_ocimem_b | (wr_pend_q & ~wr_done);
    rd_pend_d = take_no_action_ocimem_a | (rd_pend_q & ~rd_done);
    wdata_d = take_action_ocimem_b ? jdo[JDO_WDATA_LSB +: OCIMEM_DATA_W] : wdata_q;
    err_d = take_action_ocimem_a ? 1'b0 :
            err_q | (take_action_ocimem_b & wr_pend_q) | (take_no_action_ocimem_a & rd_pend_q);
  end
  // Command state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      jptr_q <= '0;
      wr_pend_q <= 1'b0;
      rd_pend_q <= 1'b0;
      wdata_q <= '0;
      err_q <= 1'b0;
    end else begin
      jptr_q <= jptr_d;
      wr_pend_q <= wr_pend_d;
      rd_pend_q <= rd_pend_d;
      wdata_q <= wdata_d;
      err_q <= err_d;
    end
  end
  assign jptr = jptr_q;
  assign wr_pend = wr_pend_q;
  assign rd_pend = rd_pend_q;
  assign wdata = wdata_q;
  assign monitor_error = err_q;
endmodule

// File: rtl/ocimem_access_arbiter.sv
// ocimem_access_arbiter: shares the OCI RAM between the CPU Avalon slave and JTAG debug commands (OCIMEM_JTAG_AUTOINC_EN enables JTAG pointer auto-increment)
module ocimem_access_arbiter
  import ocimem_arb_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = OCIMEM_DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [DATA_W-1:0] avs_writedata,
  input  logic [3:0]        avs_byteenable,
  output logic [DATA_W-1:0] avs_readdata,
  output logic              avs_waitrequest,
  output logic              ram_en,
  output logic              ram_wren,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [3:0]        ram_byteen,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);
  ocimem_state_e state_q, state_d;
  logic last_jtag_q, last_jtag_d, ready_q, ready_d;
  logic [DATA_W-1:0] mon_q, mon_d;
  logic [ADDR_W-1:0] jptr;
  logic [DATA_W-1:0] wdata;
  logic wr_pend, rd_pend, cpu_req, jtag_req, idle, grant_jtag, grant_cpu, wr_done, rd_done;
  ocimem_jtag_cmd_latch #(.ADDR_W(ADDR_W)) u_latch (
    .clk(clk), .reset_n(reset_n), .jdo(jdo),
    .take_action_ocimem_a(take_action_ocimem_a),
    .take_action_ocimem_b(take_action_ocimem_b),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .wr_done(wr_done), .rd_done(rd_done),
    .jptr(jptr), .wr_pend(wr_pend), .rd_pend(rd_pend),
    .wdata(wdata), .monitor_error(monitor_error)
  );
  // Round-robin grant in IDLE, RAM port steering and Avalon handshake
  always_comb begin
    cpu_req = avs_read | avs_write;
    jtag_req = wr_pend | rd_pend;
    idle = state_q == IDLE;
    grant_jtag = idle & jtag_req & (~cpu_req | ~last_jtag_q);
    grant_cpu = idle & cpu_req & ~grant_jtag;
    wr_done = grant_jtag & wr_pend;
    rd_done = state_q == JTAG_RD;
    ram_en = grant_jtag | grant_cpu;
    ram_wren = grant_jtag ? wr_pend : grant_cpu & avs_write;
    ram_addr = grant_jtag ? jptr : grant_cpu ? avs_address : '0;
    ram_byteen = grant_jtag ? 4'hF : grant_cpu ? avs_byteenable : 4'h0;
    ram_wdata = grant_jtag ? wdata : grant_cpu ? avs_writedata : '0;
    avs_readdata = state_q == CPU_RD ? ram_rdata : '0;
    avs_waitrequest = ~((grant_cpu & avs_write) | (state_q == CPU_RD));
    state_d = (grant_cpu && !avs_write) ? CPU_RD : (grant_jtag && !wr_pend) ? JTAG_RD : IDLE;
    last_jtag_d = grant_jtag ? 1'b1 : grant_cpu ? 1'b0 : last_jtag_q;
    mon_d = rd_done ? ram_rdata : mon_q;
    ready_d = take_action_ocimem_a ? 1'b0 : rd_done ? 1'b1 : ready_q;
  end
  // FSM, fairness flag and JTAG read-back registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      last_jtag_q <= 1'b0;
      mon_q <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_jtag_q <= last_jtag_d;
      mon_q <= mon_d;
      ready_q <= ready_d;
    end
  end
  assign MonDReg = mon_q;
  assign monitor_ready = ready_q;
endmodule

// File: tb/tb_ocimem_access_arbiter.sv
// tb_ocimem_access_arbiter: vector table, directed corner cases and random transactions against a memory-level model
module tb_ocimem_access_arbiter;
`ifdef OCIMEM_JTAG_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic [37:0] jdo = '0;
  logic take_action_ocimem_a = 1'b0, take_action_ocimem_b = 1'b0, take_no_action_ocimem_a = 1'b0;
  logic [7:0] avs_address = '0;
  logic avs_read = 1'b0, avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic [3:0] avs_byteenable = '0;
  logic [31:0] avs_readdata, ram_wdata, MonDReg;
  logic [31:0] ram_rdata = '0;
  logic avs_waitrequest, ram_en, ram_wren, monitor_ready, monitor_error;
  logic [7:0] ram_addr;
  logic [3:0] ram_byteen;
  logic mem_clr = 1'b1;
  logic [31:0] mem [256];
  logic [31:0] exp_mem [256];
  logic [7:0] mj = '0;
  int n_chk = 0, n_fail = 0;
  typedef struct { logic [7:0] addr; logic [31:0] data; logic [3:0] be; logic [31:0] exp; } vec_t;
  vec_t vt [6];
  int cwq [6] = '{1, 0, 1, 1, 1, 0};
  int cen [6] = '{1, 0, 1, 0, 1, 0};
  int cad [6] = '{'h20, 0, 'h10, 0, 'h20, 0};
  int crdy [6] = '{0, 0, 0, 0, 1, 1};

  always #5 clk = ~clk;

  ocimem_access_arbiter dut (
    .clk(clk), .reset_n(reset_n), .jdo(jdo),
    .take_action_ocimem_a(take_action_ocimem_a),
    .take_action_ocimem_b(take_action_ocimem_b),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
    .avs_readdata(avs_readdata), .avs_waitrequest(avs_waitrequest),
    .ram_en(ram_en), .ram_wren(ram_wren), .ram_addr(ram_addr),
    .ram_byteen(ram_byteen), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .MonDReg(MonDReg), .monitor_ready(monitor_ready), .monitor_error(monitor_error)
  );

  // OCI RAM with one-cycle read latency
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else if (ram_en) begin
      if (ram_wren) begin
        for (int b = 0; b < 4; b++) if (ram_byteen[b]) mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
      end else ram_rdata <= mem[ram_addr];
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, required finish before 2ms");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  task automatic mwr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    for (int b = 0; b < 4; b++) if (be[b]) exp_mem[a][b*8 +: 8] = d[b*8 +: 8];
  endtask

  task automatic cpu_op(input bit wr, input logic [7:0] a, input logic [31:0] d, input logic [3:0] be,
                        output logic [31:0] rd, output bit ok, output int lat);
    avs_write = wr; avs_read = !wr; avs_address = a; avs_writedata = d; avs_byteenable = be;
    ok = 0; rd = '0; lat = -1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (!avs_waitrequest) begin ok = 1; rd = avs_readdata; lat = i; break; end
      tick();
    end
    tick();
    avs_write = 0; avs_read = 0;
  endtask

  task automatic pulse_a(input logic [7:0] a);
    jdo = '0; jdo[24:17] = a; take_action_ocimem_a = 1;
    tick();
    take_action_ocimem_a = 0; mj = a;
  endtask

  task automatic pulse_b(input logic [31:0] d);
    jdo = '0; jdo[34:3] = d; take_action_ocimem_b = 1;
    tick();
    take_action_ocimem_b = 0;
  endtask

  task automatic pulse_c();
    take_no_action_ocimem_a = 1;
    tick();
    take_no_action_ocimem_a = 0;
  endtask

  task automatic jwr(input string nm, input logic [31:0] d);
    pulse_b(d);
    @(negedge clk);
    chk({nm, " en"}, ram_en, 1);
    chk({nm, " wren"}, ram_wren, 1);
    chk({nm, " addr"}, ram_addr, mj);
    chk({nm, " wdata"}, ram_wdata, d);
    mwr(mj, d, 4'hF);
    mj = mj + 8'(AUTOINC);
    tick();
  endtask

  task automatic jrd(input string nm);
    pulse_c();
    tick(); tick();
    @(negedge clk);
    chk({nm, " ready"}, monitor_ready, 1);
    chk({nm, " data"}, MonDReg, exp_mem[mj]);
    mj = mj + 8'(AUTOINC);
    tick();
  endtask

  initial begin
    logic [31:0] rd;
    bit ok;
    int lat, ncpu;
    logic [7:0] ra;
    logic [31:0] rdat;
    vt[0] = '{8'h10, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF};
    vt[1] = '{8'h20, 32'hCAFEF00D, 4'hF, 32'hCAFEF00D};
    vt[2] = '{8'h20, 32'h11223344, 4'h5, 32'hCA22F044};
    vt[3] = '{8'hFF, 32'hA5A5A5A5, 4'hF, 32'hA5A5A5A5};
    vt[4] = '{8'h05, 32'h55AA0005, 4'hF, 32'h55AA0005};
    vt[5] = '{8'h06, 32'h66BB0006, 4'h3, 32'h00000006};
    for (int i = 0; i < 256; i++) exp_mem[i] = '0;
    #2 reset_n = 0;
    @(posedge clk); #1 mem_clr = 0;
    @(negedge clk);
    chk("rst waitrequest", avs_waitrequest, 1);
    chk("rst readdata", avs_readdata, 0);
    chk("rst MonDReg", MonDReg, 0);
    chk("rst ready", monitor_ready, 0);
    chk("rst error", monitor_error, 0);
    chk("rst ram_en", ram_en, 0);
    chk("rst ram_wren", ram_wren, 0);
    chk("rst ram_addr", ram_addr, 0);
    chk("rst ram_byteen", ram_byteen, 0);
    chk("rst ram_wdata", ram_wdata, 0);
    reset_n = 1;
    tick();

    for (int i = 0; i < 6; i++) begin
      cpu_op(1, vt[i].addr, vt[i].data, vt[i].be, rd, ok, lat);
      chk($sformatf("vec%0d wr done", i), ok, 1);
      chk($sformatf("vec%0d wr latency", i), lat, 0);
      mwr(vt[i].addr, vt[i].data, vt[i].be);
      cpu_op(0, vt[i].addr, '0, 4'hF, rd, ok, lat);
      chk($sformatf("vec%0d rd done", i), ok, 1);
      chk($sformatf("vec%0d rd latency", i), lat, 1);
      chk($sformatf("vec%0d rd data", i), rd, vt[i].exp);
    end

    pulse_a(8'hFF);
    pulse_b(32'h12345678);
    @(negedge clk);
    chk("jwr en", ram_en, 1);
    chk("jwr wren", ram_wren, 1);
    chk("jwr addr", ram_addr, 8'hFF);
    chk("jwr wdata", ram_wdata, 32'h12345678);
    chk("jwr byteen", ram_byteen, 4'hF);
    chk("jwr waitrequest", avs_waitrequest, 1);
    mwr(8'hFF, 32'h12345678, 4'hF);
    tick();
    pulse_a(8'hFF);
    pulse_c();
    @(negedge clk);
    chk("jrd en", ram_en, 1);
    chk("jrd wren", ram_wren, 0);
    chk("jrd addr", ram_addr, 8'hFF);
    chk("jrd ready early", monitor_ready, 0);
    tick();
    @(negedge clk);
    chk("jrd ready in ram cycle", monitor_ready, 0);
    tick();
    @(negedge clk);
    chk("jrd ready", monitor_ready, 1);
    chk("jrd MonDReg", MonDReg, 32'h12345678);
    mj = mj + 8'(AUTOINC);
    tick();
    jwr("wrap ptr", 32'h0BADCAFE);

    pulse_a(8'h10);
    avs_read = 1; avs_address = 8'h20; take_no_action_ocimem_a = 1;
    for (int u = 0; u < 6; u++) begin
      @(negedge clk);
      chk($sformatf("arb%0d waitrequest", u), avs_waitrequest, cwq[u]);
      chk($sformatf("arb%0d ram_en", u), ram_en, cen[u]);
      if (cen[u] != 0) chk($sformatf("arb%0d ram_addr", u), ram_addr, cad[u]);
      chk($sformatf("arb%0d ready", u), monitor_ready, crdy[u]);
      if (u == 1 || u == 5) chk($sformatf("arb%0d readdata", u), avs_readdata, exp_mem[8'h20]);
      if (u == 4) chk("arb MonDReg", MonDReg, exp_mem[8'h10]);
      tick();
      take_no_action_ocimem_a = 0;
    end
    avs_read = 0;
    mj = mj + 8'(AUTOINC);
    tick();

    avs_read = 1; avs_address = 8'h10; jdo = '0; jdo[34:3] = 32'h11111111; take_action_ocimem_b = 1;
    @(negedge clk);
    chk("ovr grant cpu", avs_waitrequest, 1);
    tick();
    jdo[34:3] = 32'h22222222;
    @(negedge clk);
    chk("ovr cpu done", avs_waitrequest, 0);
    tick();
    take_action_ocimem_b = 0; avs_read = 0;
    @(negedge clk);
    chk("ovr error", monitor_error, 1);
    chk("ovr wr en", ram_en, 1);
    chk("ovr wr wren", ram_wren, 1);
    chk("ovr wr addr", ram_addr, mj);
    chk("ovr wr data", ram_wdata, 32'h22222222);
    mwr(mj, 32'h22222222, 4'hF);
    mj = mj + 8'(AUTOINC);
    tick();
    @(negedge clk);
    chk("ovr single write", ram_en, 0);
    chk("ovr error held", monitor_error, 1);
    tick();
    pulse_a(8'h05);
    @(negedge clk);
    chk("ovr error cleared", monitor_error, 0);
    tick();

    jrd("same addr 1st");
    jrd("same addr 2nd");
    jwr("ptr after reads", 32'h0F0F0F0F);

    avs_read = 1; avs_address = 8'h20;
    tick();
    @(negedge clk);
    chk("rst mid cpu_rd", avs_waitrequest, 0);
    #2 reset_n = 0; avs_read = 0;
    #1;
    chk("arst waitrequest", avs_waitrequest, 1);
    chk("arst readdata", avs_readdata, 0);
    chk("arst MonDReg", MonDReg, 0);
    chk("arst ready", monitor_ready, 0);
    chk("arst ram_en", ram_en, 0);
    @(negedge clk);
    reset_n = 1; mj = '0;
    tick();
    @(negedge clk);
    chk("post rst waitrequest", avs_waitrequest, 1);
    tick();

    for (int it = 0; it < 300; it++) begin
      int op;
      op = $urandom_range(0, 5);
      ra = 8'($urandom);
      rdat = $urandom;
      case (op)
        0: begin
          logic [3:0] be;
          be = 4'($urandom);
          cpu_op(1, ra, rdat, be, rd, ok, lat);
          chk("rnd cpu wr done", ok, 1);
          mwr(ra, rdat, be);
        end
        1: begin
          cpu_op(0, ra, '0, 4'hF, rd, ok, lat);
          chk("rnd cpu rd done", ok, 1);
          chk("rnd cpu rd data", rd, exp_mem[ra]);
        end
        2: begin
          pulse_a(ra);
          @(negedge clk);
          chk("rnd load ready", monitor_ready, 0);
          chk("rnd load error", monitor_error, 0);
          tick();
        end
        3: jwr("rnd jwr", rdat);
        4: jrd("rnd jrd");
        default: begin
          avs_read = 1; avs_address = ra; take_no_action_ocimem_a = 1; ncpu = 0;
          for (int u = 0; u < 6; u++) begin
            @(negedge clk);
            if (!avs_waitrequest) begin
              ncpu++;
              chk("rnd mix cpu data", avs_readdata, exp_mem[ra]);
            end
            tick();
            take_no_action_ocimem_a = 0;
          end
          avs_read = 0;
          @(negedge clk);
          chk("rnd mix cpu count", ncpu, 2);
          chk("rnd mix ready", monitor_ready, 1);
          chk("rnd mix jtag data", MonDReg, exp_mem[mj]);
          mj = mj + 8'(AUTOINC);
          tick();
        end
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
